// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signal bundle for mem_access_unit.
// slave is the unit's view; master is the pipeline plus memory side.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  logic              rom_rden;
  logic              rom_wren;
  logic [DATA_W-1:0] rom_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rom_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output rom_addr, rom_wdata, rom_rden, rom_wren
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rom_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  rom_addr, rom_wdata, rom_rden, rom_wren
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer over a 64-bit big-endian, 1-cycle-read data memory.
// Optional `MEM_ALIGN_CHECK_EN: misaligned accesses fault instead of being aligned down.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    CAP   = 3'd4
  } state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] rom_wdata_q;
  logic              rom_rden_q;
  logic              rom_wren_q;

  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic [DATA_W-1:0] wdata_q;

  // Request-side alignment decode
  logic [2:0] req_off_c;
  logic [2:0] align_mask_c;
  logic [2:0] off_eff_c;
  logic       misalign_c;

  assign req_off_c = bus.req_addr[2:0];

  always_comb begin
    case (bus.req_size)
      2'd0:    align_mask_c = 3'b000;
      2'd1:    align_mask_c = 3'b001;
      2'd2:    align_mask_c = 3'b011;
      default: align_mask_c = 3'b111;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = |(req_off_c & align_mask_c);
  assign off_eff_c  = req_off_c;
`else
  assign misalign_c = 1'b0;
  assign off_eff_c  = req_off_c & ~align_mask_c;
`endif

  // Lane geometry of the latched op: field sits shamt_c bits above bit 0
  logic [3:0]        nbytes_c;
  logic [3:0]        end_lane_c;
  logic [2:0]        pad_c;
  logic [5:0]        shamt_c;
  logic [DATA_W-1:0] lowmask_c;
  logic [DATA_W-1:0] field_c;
  logic              sign_c;
  logic [DATA_W-1:0] load_d;
  logic [DATA_W-1:0] merge_d;

  always_comb begin
    nbytes_c   = 4'd1 << size_q;
    end_lane_c = {1'b0, off_q} + nbytes_c;
    pad_c      = 3'(4'd8 - end_lane_c);
    shamt_c    = {pad_c, 3'b000};
    case (size_q)
      2'd0:    lowmask_c = 64'h0000_0000_0000_00FF;
      2'd1:    lowmask_c = 64'h0000_0000_0000_FFFF;
      2'd2:    lowmask_c = 64'h0000_0000_FFFF_FFFF;
      default: lowmask_c = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    field_c = (bus.rom_rdata >> shamt_c) & lowmask_c;
    case (size_q)
      2'd0:    sign_c = field_c[7];
      2'd1:    sign_c = field_c[15];
      2'd2:    sign_c = field_c[31];
      default: sign_c = 1'b0;
    endcase
    load_d  = (signed_q && sign_c) ? (field_c | ~lowmask_c) : field_c;
    merge_d = (bus.rom_rdata & ~(lowmask_c << shamt_c)) | ((wdata_q & lowmask_c) << shamt_c);
  end

  // Sequencer: one op in flight, every output registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      rom_rden_q  <= 1'b0;
      rom_wren_q  <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 3'd0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rom_rden_q  <= 1'b0;
      rom_wren_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            we_q     <= bus.req_we;
            signed_q <= bus.req_signed;
            size_q   <= bus.req_size;
            off_q    <= off_eff_c;
            wdata_q  <= bus.req_wdata;
            if (misalign_c) begin
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              rom_addr_q  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
              req_ready_q <= 1'b0;
              if (bus.req_we && (bus.req_size == 2'd3)) begin
                state_q     <= WR;
                rom_wren_q  <= 1'b1;
                rom_wdata_q <= bus.req_wdata;
              end else begin
                state_q    <= RD;
                rom_rden_q <= 1'b1;
              end
            end
          end
        end
        RD: state_q <= we_q ? MERGE : CAP;
        MERGE: begin
          rom_wdata_q <= merge_d;
          rom_wren_q  <= 1'b1;
          state_q     <= WR;
        end
        WR: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        CAP: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_d;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.rom_rden  = rom_rden_q;
  assign bus.rom_wren  = rom_wren_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed ops, randomized ops and a mid-op reset,
// checked against a byte-lane model of the memory and the op timing.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: 8 dwords, 1-cycle registered read, preload port for the bench
  logic [63:0] mem [0:7];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [63:0] pl_data = 64'd0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.rom_wren) mem[bus.rom_addr[5:3]] <= bus.rom_wdata;
    if (bus.rom_rden) bus.rom_rdata <= mem[bus.rom_addr[5:3]];
  end

  logic [63:0] ref_mem [0:7];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [63:0] d);
    pl_en = 1'b1; pl_idx = 3'(idx); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Issue one op at a negedge, observe it to completion, compare with the model
  task automatic run_op(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd);
    int n, off, idx, e_lat, e_nr, e_nw, lat, nr, nw, ovl;
    logic [63:0] d, v, e_rd, e_wd;
    logic e_f, got, f;
    n = 1 << sz; off = int'(addr[2:0]); idx = int'(addr[5:3]);
    d = ref_mem[idx]; v = 64'd0; e_f = 1'b0; e_rd = 64'd0; e_wd = d;
`ifdef MEM_ALIGN_CHECK_EN
    if (off % n != 0) e_f = 1'b1;
`else
    off = off - (off % n);
`endif
    if (e_f) begin
      e_lat = 1; e_nr = 0; e_nw = 0;
    end else if (!we) begin
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(d[63-8*(off+i) -: 8]);
      if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      e_rd = v; e_lat = 3; e_nr = 1; e_nw = 0;
    end else begin
      for (int i = 0; i < n; i++) e_wd[63-8*(off+i) -: 8] = wd[8*(n-1-i) +: 8];
      e_lat = (n == 8) ? 2 : 4; e_nr = (n == 8) ? 0 : 1; e_nw = 1;
    end

    chk("ready_before_req", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
    got = 1'b0; f = 1'b0; rd = 64'hX; lat = 0; nr = 0; nw = 0; ovl = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.rom_rden && bus.rom_wren) ovl++;
      if (bus.rom_rden) begin
        nr++;
        chk("rden_addr", 64'(bus.rom_addr), 64'({addr[31:3], 3'b000}));
      end
      if (bus.rom_wren) begin
        nw++;
        chk("wren_addr", 64'(bus.rom_addr), 64'({addr[31:3], 3'b000}));
        chk("wren_wdata", bus.rom_wdata, e_wd);
      end
      if (bus.rsp_valid) begin
        got = 1'b1; lat = c; rd = bus.rsp_rdata; f = bus.rsp_fault;
      end
    end
    chk("rsp_seen", 64'(got), 64'd1);
    chk("latency", 64'(lat), 64'(e_lat));
    chk("rsp_rdata", rd, e_rd);
    chk("rsp_fault", 64'(f), 64'(e_f));
    chk("rden_count", 64'(nr), 64'(e_nr));
    chk("wren_count", 64'(nw), 64'(e_nw));
    chk("rd_wr_overlap", 64'(ovl), 64'd0);
    if (we && !e_f) ref_mem[idx] = e_wd;
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] saved;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_rden", 64'(bus.rom_rden), 64'd0);
    chk("rst_wren", 64'(bus.rom_wren), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
    chk("rst_rom_wdata", bus.rom_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) preload(i, {$urandom, $urandom});
    preload(2, 64'h0011_2233_4455_6677);
    preload(6, 64'h80F0_E0D0_C0B0_A090);

    run_op(1'b0, 2'd3, 1'b0, 32'h10, 64'd0, r);
    chk("ldr_0x10", r, 64'h0011_2233_4455_6677);
    run_op(1'b0, 2'd0, 1'b1, 32'h15, 64'd0, r);
    chk("ldrb_s_0x15", r, 64'h0000_0000_0000_0055);
    run_op(1'b0, 2'd0, 1'b1, 32'h30, 64'd0, r);
    chk("ldrb_s_0x30", r, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1'b1, 2'd0, 1'b0, 32'h13, 64'h0000_0000_0000_00AB, r);
    chk("strb_mem", mem[2], 64'h0011_22AB_4455_6677);
    run_op(1'b1, 2'd3, 1'b0, 32'h20, 64'hDEAD_BEEF_CAFE_F00D, r);
    run_op(1'b0, 2'd1, 1'b0, 32'h22, 64'd0, r);
    chk("ldrh_u_0x22", r, 64'h0000_0000_0000_BEEF);
    run_op(1'b0, 2'd2, 1'b0, 32'h12, 64'd0, r);
    run_op(1'b0, 2'd1, 1'b1, 32'h37, 64'd0, r);

    for (int k = 0; k < 40; k++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), {$urandom, $urandom}, r);
    end

    // Reset while a half-word store sits in MERGE
    saved = ref_mem[1];
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
    bus.req_signed = 1'b0; bus.req_addr = 32'h08; bus.req_wdata = 64'h1234;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_rd_phase", 64'(bus.rom_rden), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rden", 64'(bus.rom_rden), 64'd0);
    chk("abort_wren", 64'(bus.rom_wren), 64'd0);
    chk("abort_ready", 64'(bus.req_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      chk("abort_no_wren", 64'(bus.rom_wren), 64'd0);
      chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("abort_ready_hold", 64'(bus.req_ready), 64'd1);
    end
    chk("abort_mem_intact", mem[1], saved);

    run_op(1'b0, 2'd3, 1'b0, 32'h08, 64'd0, r);
    for (int i = 0; i < 8; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
